imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the fetch stage, which only reads instruction memory.
- Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words into an internal instruction RAM.
- Serves the combinational fetch read port addressed by PC.
- Holds the core via core_hold while a load is in progress.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words in RAM.
- ADDR_W, 8, word-address width; equals log2(DEPTH_WORDS).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- load_len  input  ADDR_W+1  number of words to load; sampled on the accepted load_start.
- rx_valid  input  1  byte-stream valid.
- rx_data  input  8  byte-stream data; first byte is the least significant byte of word 0.
- rx_ready  output  1  byte-stream ready.
- core_hold  output  1  high while loading; the core must not advance PC.
- load_done  output  1  one-cycle pulse when the last word is written.
- words_loaded  output  ADDR_W+1  count of words written in the current or last load.
- pc  input  32  fetch address from the IF stage.
- Instr  output  32  instruction at pc; combinational read.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - rx_ready=0, core_hold=0, load_done=0, words_loaded=0, byte_idx=0, wr_ptr=0, shift register cleared.
  - Instr is forced to 32'b0 while reset is high.
  - RAM contents are not cleared.
- States: IDLE, LOAD, DONE.
- IDLE or DONE, load_start=1:
  - Latch eff_len = min(load_len, DEPTH_WORDS).
  - Clear wr_ptr, byte_idx and words_loaded.
  - If eff_len==0, go to DONE and pulse load_done on the next cycle. Otherwise go to LOAD.
- LOAD:
  - rx_ready=1 and core_hold=1.
  - A byte is accepted when rx_valid&&rx_ready at a rising edge; the byte goes into lane byte_idx (lane 0 = bits 7:0) and byte_idx increments mod 4.
  - On the 4th accepted byte (byte_idx==3):
    - Write the assembled word {rx_data, lanes 2..0} to mem[wr_ptr] on that same edge.
    - wr_ptr++ and words_loaded++.
  - If that write makes wr_ptr==eff_len: go to DONE, assert load_done for exactly the following cycle, then rx_ready=0 and core_hold=0.
  - rx_valid=0 simply stalls with no state change.
  - load_start in LOAD is ignored.
- DONE:
  - rx_ready=0 and core_hold=0.
  - words_loaded holds its value.
  - Incoming bytes are not accepted.
  - A new load_start restarts the sequence.
- Fetch read:
  - Instr = mem[pc[ADDR_W+1:2]].
  - pc[1:0] is ignored.
  - If pc[31:ADDR_W+2] != 0, Instr = 32'b0.
  - Read is asynchronous.
  - A write at an edge is visible on Instr in the cycle after that edge; before the edge Instr shows the old value.
- Reset mid-LOAD:
  - Aborts the load and returns to IDLE with core_hold=0.
  - Words already written remain; a partial word in the shift register is discarded.
- Byte stream ending mid-word with no further bytes: the block stays in LOAD indefinitely. Reset is the only exit.
- Width rules: wr_ptr and words_loaded are ADDR_W+1 bits so that a count of DEPTH_WORDS is representable; wr_ptr never indexes at or above DEPTH_WORDS.

Decomposition:
- Shared package (imem_pkg) holds:
  - State encoding constants: ST_IDLE=2'd0, ST_LOAD=2'd1, ST_DONE=2'd2.
  - BYTE_W=8.
  - BYTES_PER_WORD=4.
  - NOP_WORD=32'b0.
- One sub-module, imem_ram_1w1r: DEPTH_WORDS x 32 RAM with synchronous write (we, waddr, wdata) and asynchronous read (raddr → rdata).
- The FSM, byte assembler and fetch address decode live in imem_loader.

Test Plan:
1. Reset, then load_start with load_len=2, then bytes 13,00,00,00,93,00,10,00 with rx_valid held high → words_loaded=2, load_done pulses once, mem[0]=32'h00000013, mem[1]=32'h00100093, core_hold high for exactly the LOAD cycles.
2. After scenario 1, pc=0/4/5/8 → Instr=00000013, 00100093, 00100093, then the unwritten mem[2] value; pc=32'h00000400 → Instr=0.
3. load_len=1 with rx_valid toggling every other cycle → 4 bytes accepted in 8 cycles, word 32'hDEADBEEF from bytes EF,BE,AD,DE; no acceptance while rx_valid=0.
4. load_len=0 → no LOAD cycle, core_hold stays 0, load_done pulses one cycle later, words_loaded=0.
5. load_len=300 (greater than 256) → load clamps to 256 words, load_done after the 1024th byte, rx_ready=0 afterwards.
6. Assert reset after 6 bytes of a 3-word load → state IDLE, core_hold=0, words_loaded=0; mem[0] keeps the first word; the partial second word is not written; Instr=0 while reset is high.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// byte/word geometry and the word returned for out-of-range fetches.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          BYTE_W         = 8;
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] NOP_WORD       = 32'b0;

endpackage

// File: rtl/imem_ram_1w1r.sv
// Instruction RAM: one synchronous write port for the loader and one
// asynchronous read port for fetch. Contents survive reset.
module imem_ram_1w1r #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Storage write; deliberately has no reset so a program survives a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction RAM, holding the core
// while loading, and serves the combinational fetch port addressed by PC.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              core_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded,
    input  logic [31:0]       pc,
    output logic [31:0]       Instr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] ZERO_L  = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_t                            state_r;
    state_t                            state_nxt_s;
    logic [ADDR_W:0]                   eff_len_r;
    logic [ADDR_W:0]                   wr_ptr_r;
    logic [ADDR_W:0]                   words_loaded_r;
    logic [ADDR_W:0]                   clamp_len_s;
    logic [1:0]                        byte_idx_r;
    logic [(BYTES_PER_WORD-1)*BYTE_W-1:0] lanes_r;
    logic                              busy_r;
    logic                              load_done_r;
    logic                              start_ok_s;
    logic                              accept_s;
    logic                              wr_fire_s;
    logic                              last_word_s;
    logic                              done_enter_s;
    logic [31:0]                       wdata_s;
    logic [31:0]                       rdata_s;
    logic                              unused_pc_s;

    assign clamp_len_s  = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    assign start_ok_s   = load_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign accept_s     = (state_r == ST_LOAD) && rx_valid;
    assign wr_fire_s    = accept_s && (byte_idx_r == 2'd3);
    assign last_word_s  = ((wr_ptr_r + ONE_L) == eff_len_r);
    assign done_enter_s = (start_ok_s && (clamp_len_s == ZERO_L)) || (wr_fire_s && last_word_s);
    assign wdata_s      = {rx_data, lanes_r};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a zero-length load skips straight to DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    if (clamp_len_s == ZERO_L) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD: begin
                if (wr_fire_s && last_word_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Byte assembly, write pointer, counters and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eff_len_r      <= ZERO_L;
            wr_ptr_r       <= ZERO_L;
            words_loaded_r <= ZERO_L;
            byte_idx_r     <= 2'd0;
            lanes_r        <= '0;
            busy_r         <= 1'b0;
            load_done_r    <= 1'b0;
        end else begin
            busy_r      <= (state_nxt_s == ST_LOAD);
            load_done_r <= done_enter_s;
            if (start_ok_s) begin
                eff_len_r      <= clamp_len_s;
                wr_ptr_r       <= ZERO_L;
                words_loaded_r <= ZERO_L;
                byte_idx_r     <= 2'd0;
                lanes_r        <= '0;
            end else if (accept_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                case (byte_idx_r)
                    2'd0:    lanes_r[7:0]   <= rx_data;
                    2'd1:    lanes_r[15:8]  <= rx_data;
                    2'd2:    lanes_r[23:16] <= rx_data;
                    default: begin
                        wr_ptr_r       <= wr_ptr_r + ONE_L;
                        words_loaded_r <= words_loaded_r + ONE_L;
                    end
                endcase
            end
        end
    end

    imem_ram_1w1r #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (wdata_s),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (rdata_s)
    );

    // Fetch port: addresses beyond the RAM, and any fetch during reset, read as NOP.
    always_comb begin
        Instr = NOP_WORD;
        if (reset) begin
            Instr = NOP_WORD;
        end else if (|pc[31:ADDR_W+2]) begin
            Instr = NOP_WORD;
        end else begin
            Instr = rdata_s;
        end
    end

    assign unused_pc_s  = ^pc[1:0];
    assign rx_ready     = busy_r;
    assign core_hold    = busy_r;
    assign load_done    = load_done_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a transaction-level model (byte queue plus
// word array) predicts every output each cycle; literal checks pin the model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [8:0]  load_len = 9'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        core_hold;
    logic        load_done;
    logic [8:0]  words_loaded;
    logic [31:0] pc = 32'd0;
    logic [31:0] Instr;

    int n_cmp = 0;
    int n_bad = 0;
    int hold_cnt = 0;
    int done_cnt = 0;
    int h0, d0;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_len     (load_len),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .words_loaded (words_loaded),
        .pc           (pc),
        .Instr        (Instr)
    );

    always #5 clk = ~clk;

    // Model: a load is "active" until eff_len words have been collected.
    bit          m_loading = 1'b0;
    bit          m_done = 1'b0;
    int          m_words = 0;
    int          m_eff = 0;
    logic [7:0]  m_part[$];
    logic [31:0] m_mem[256];
    bit          m_written[256];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_loading <= 1'b0;
            m_done    <= 1'b0;
            m_words   <= 0;
            m_part.delete();
        end else begin
            m_done <= 1'b0;
            if (!m_loading && load_start) begin
                m_eff   <= (load_len > 9'd256) ? 256 : int'(load_len);
                m_words <= 0;
                m_part.delete();
                if (load_len == 9'd0) m_done <= 1'b1;
                else m_loading <= 1'b1;
            end else if (m_loading && rx_valid) begin
                if (m_part.size() == 3) begin
                    m_mem[m_words]     <= {rx_data, m_part[2], m_part[1], m_part[0]};
                    m_written[m_words] <= 1'b1;
                    m_words            <= m_words + 1;
                    m_part.delete();
                    if (m_words + 1 == m_eff) begin
                        m_loading <= 1'b0;
                        m_done    <= 1'b1;
                    end
                end else begin
                    m_part.push_back(rx_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("rx_ready", {31'b0, rx_ready}, {31'b0, m_loading});
        check("core_hold", {31'b0, core_hold}, {31'b0, m_loading});
        check("load_done", {31'b0, load_done}, {31'b0, m_done});
        check("words_loaded", {23'b0, words_loaded}, 32'(m_words));
        if (reset || (pc[31:10] != 22'd0)) check("instr_nop", Instr, 32'h0000_0000);
        else if (m_written[pc[9:2]]) check("instr", Instr, m_mem[pc[9:2]]);
        hold_cnt += int'(core_hold);
        done_cnt += int'(load_done);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [8:0] n);
        load_start = 1'b1;
        load_len   = n;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic gap();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pin_instr(input string name, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        check(name, Instr, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_words", {23'b0, words_loaded}, 32'd0);
        check("rst_hold", {31'b0, core_hold}, 32'd0);
        check("rst_instr", Instr, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: two-word load with continuous valid
        h0 = hold_cnt; d0 = done_cnt;
        start(9'd2);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        gap(); gap();
        check("t1_hold_cycles", 32'(hold_cnt - h0), 32'd8);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_words", {23'b0, words_loaded}, 32'd2);

        // 2: fetch decode
        pin_instr("t2_pc0", 32'h0, 32'h0000_0013); tick();
        pin_instr("t2_pc4", 32'h4, 32'h0010_0093); tick();
        pin_instr("t2_pc5", 32'h5, 32'h0010_0093); tick();
        pc = 32'h8; tick();
        pin_instr("t2_pc400", 32'h400, 32'h0000_0000); tick();
        pc = 32'h0;

        // 3: one word with valid toggling
        h0 = hold_cnt;
        start(9'd1);
        send(8'hEF); gap(); send(8'hBE); gap();
        send(8'hAD); gap(); send(8'hDE); gap();
        gap();
        check("t3_hold_cycles", 32'(hold_cnt - h0), 32'd7);
        pin_instr("t3_word", 32'h0, 32'hDEAD_BEEF);

        // 4: zero-length load
        h0 = hold_cnt; d0 = done_cnt;
        start(9'd0);
        tick(); tick();
        check("t4_hold_cycles", 32'(hold_cnt - h0), 32'd0);
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t4_words", {23'b0, words_loaded}, 32'd0);

        // 5: oversize load clamps to RAM depth; trailing bytes are refused
        h0 = hold_cnt; d0 = done_cnt;
        start(9'd300);
        for (int i = 0; i < 1024; i++) send(8'(i));
        send(8'hAA); send(8'hBB); send(8'hCC);
        gap();
        check("t5_hold_cycles", 32'(hold_cnt - h0), 32'd1024);
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t5_words", {23'b0, words_loaded}, 32'd256);
        check("t5_ready", {31'b0, rx_ready}, 32'd0);
        pin_instr("t5_first", 32'h0, 32'h0302_0100);
        pin_instr("t5_last", 32'h3FC, 32'hFFFE_FDFC);
        tick();

        // 6: reset in the middle of the second word
        pc = 32'h0;
        start(9'd3);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        reset = 1'b1;
        rx_valid = 1'b0;
        #1;
        check("t6_rst_instr", Instr, 32'd0);
        check("t6_rst_hold", {31'b0, core_hold}, 32'd0);
        check("t6_rst_words", {23'b0, words_loaded}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        pin_instr("t6_word0", 32'h0, 32'h4433_2211);
        pin_instr("t6_word1_kept", 32'h4, 32'h0706_0504);
        pin_instr("t6_word2_kept", 32'h8, 32'h0B0A_0908);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
